// File: rtl/gray_dsr_pkg.sv
// Shared definitions for the 16-state Gray-coded source FSM: state codes, output map, obs match.
// Pure functions only; no latency or flow control.
package gray_dsr_pkg;

    localparam int N_STATES = 16;

    // State Sk is encoded as the reflected Gray code of k.
    function automatic logic [3:0] state_code(input logic [3:0] idx);
        return idx ^ (idx >> 1);
    endfunction

    function automatic logic [7:0] state_obs(input logic [3:0] idx);
        if (idx == 4'd0 || idx == 4'd15)
            return 8'h01;
        else if (idx <= 4'd7)
            return 8'h01 << idx;
        else
            return 8'h01 << (idx - 4'd7);
    endfunction

    // Set of Gray codes whose output equals obs; every state output is one-hot,
    // so zero or multi-hot observations never match anything.
    function automatic logic [15:0] match(input logic [7:0] obs);
        logic [15:0] m;
        m = '0;
        for (int k = 0; k < N_STATES; k++) begin
            if (obs == state_obs(4'(k)))
                m[state_code(4'(k))] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/gray_dsr_succ.sv
// Successor set of the source FSM: maps a Gray-indexed candidate set through one transition under cmd.
// Combinational; no flow control.
module gray_dsr_succ
    import gray_dsr_pkg::*;
(
    input  logic [15:0] set_in,
    input  logic [3:0]  cmd,
    output logic [15:0] set_out
);

    function automatic logic [3:0] next_idx(input logic [3:0] idx, input logic [3:0] c);
        case (idx)
            4'd0:    return c[0] ? 4'd1 : 4'd8;
            4'd1:    return (c[1:0] == 2'b11) ? 4'd2 : 4'd0;
            4'd2:    return 4'd3;
            4'd3:    return c[2] ? 4'd4 : 4'd1;
            4'd4:    return c[3] ? 4'd5 : 4'd12;
            4'd5:    return 4'd6;
            4'd6:    return (c != 4'd0) ? 4'd7 : 4'd4;
            4'd7:    return 4'd0;
            4'd8:    return (c[3:2] == 2'b01) ? 4'd9 : 4'd15;
            4'd9:    return 4'd10;
            4'd10:   return c[1] ? 4'd11 : 4'd9;
            4'd11:   return 4'd12;
            4'd12:   return (c[0] ^ c[1]) ? 4'd13 : 4'd14;
            4'd13:   return 4'd0;
            4'd14:   return 4'd15;
            default: return 4'd0;
        endcase
    endfunction

    always_comb begin
        set_out = '0;
        for (int k = 0; k < N_STATES; k++) begin
            if (set_in[state_code(4'(k))])
                set_out[state_code(next_idx(4'(k), cmd))] = 1'b1;
        end
    end

endmodule

// File: rtl/gray_dsr_mon.sv
// Passive monitor tracking the source FSM state from its one-hot output; flags inconsistent observations.
// Mask updates one cycle after each valid observation, aligned with the source state register; never stalls.
module gray_dsr_mon
    import gray_dsr_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       cmd,
    input  logic [7:0]       obs,
    output logic             locked,
    output logic [3:0]       state_est,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    logic [15:0] mask;
    logic [15:0] filt;
    logic [15:0] succ_set;

    assign filt = mask & match(obs);

    gray_dsr_succ u_succ (
        .set_in  (filt),
        .cmd     (cmd),
        .set_out (succ_set)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask    <= 16'h0001;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= 1'b0;
            if (in_valid) begin
                if (filt != 16'h0000) begin
                    mask <= succ_set;
                end else begin
                    // No candidate explains obs: forget history and reacquire.
                    mask <= 16'hFFFF;
                    err  <= 1'b1;
                    if (err_cnt != '1)
                        err_cnt <= err_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        locked    = ($countones(mask) == 1);
        state_est = 4'd0;
        if (locked) begin
            for (int k = 0; k < N_STATES; k++) begin
                if (mask[k])
                    state_est = 4'(k);
            end
        end
    end

endmodule

// File: tb/tb_gray_dsr_mon.sv
// Directed and lockstep checks of gray_dsr_mon against a bench-side model of the source FSM.
module tb_gray_dsr_mon;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] cmd;
    logic [7:0] obs;
    logic       locked;
    logic [3:0] state_est;
    logic       err;
    logic [7:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    logic [3:0] code_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                  4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    logic [7:0] out_tab  [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

    gray_dsr_mon #(.ERR_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .cmd       (cmd),
        .obs       (obs),
        .locked    (locked),
        .state_est (state_est),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int src_next(input int s, input logic [3:0] c);
        case (s)
            0:       return c[0] ? 1 : 8;
            1:       return (c[1:0] == 2'b11) ? 2 : 0;
            2:       return 3;
            3:       return c[2] ? 4 : 1;
            4:       return c[3] ? 5 : 12;
            5:       return 6;
            6:       return (c != 4'd0) ? 7 : 4;
            7:       return 0;
            8:       return (c[3:2] == 2'b01) ? 9 : 15;
            9:       return 10;
            10:      return c[1] ? 11 : 9;
            11:      return 12;
            12:      return (c[0] ^ c[1]) ? 13 : 14;
            13:      return 0;
            14:      return 15;
            default: return 0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        cmd      = 4'd0;
        obs      = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        // Dirty the state first so reset has something to clear.
        in_valid = 1'b1; obs = 8'h00; cmd = 4'd0;
        step();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (locked !== 1'b1 || state_est !== 4'b0000 || err !== 1'b0 || err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_state: locked=%b est=%b err=%b cnt=%0d, want 1 0000 0 0",
                     locked, state_est, err, err_cnt);
        end
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_first_lock();
        apply_reset();
        in_valid = 1'b1; cmd = 4'b0001; obs = 8'h01;
        step();
        checks++;
        if (locked !== 1'b1 || state_est !== 4'b0001 || err !== 1'b0) begin
            failures++;
            $display("FAIL first_lock: locked=%b est=%b err=%b, want 1 0001 0", locked, state_est, err);
        end
    endtask

    task automatic test_err_pulse();
        apply_reset();
        in_valid = 1'b1; cmd = 4'b0000; obs = 8'h04;
        step();
        checks++;
        if (err !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0 || state_est !== 4'b0000) begin
            failures++;
            $display("FAIL err_pulse: err=%b cnt=%0d locked=%b est=%b, want 1 1 0 0000",
                     err, err_cnt, locked, state_est);
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (err !== 1'b0 || err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL err_one_cycle: err=%b cnt=%0d, want 0 1", err, err_cnt);
        end
    endtask

    task automatic test_relock();
        apply_reset();
        in_valid = 1'b1; cmd = 4'b0000; obs = 8'h00;
        step();
        checks++;
        if (err !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0) begin
            failures++;
            $display("FAIL zero_obs_err: err=%b cnt=%0d locked=%b, want 1 1 0", err, err_cnt, locked);
        end
        obs = 8'h80;
        step();
        checks++;
        if (locked !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL relock_80: locked=%b err=%b, want 0 0", locked, err);
        end
        obs = 8'h01;
        step();
        checks++;
        if (locked !== 1'b0 || err !== 1'b0 || state_est !== 4'b0000) begin
            failures++;
            $display("FAIL relock_01: locked=%b err=%b est=%b, want 0 0 0000", locked, err, state_est);
        end
        obs = 8'h02;
        step();
        checks++;
        if (locked !== 1'b1 || state_est !== 4'b1000 || err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL relock_02: locked=%b est=%b cnt=%0d, want 1 1000 1", locked, state_est, err_cnt);
        end
    endtask

    // Runs right after test_relock: the monitor is locked on S15 with err_cnt=1.
    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b0;
            cmd      = 4'($urandom);
            obs      = 8'($urandom);
            step();
            checks++;
            if (locked !== 1'b1 || state_est !== 4'b1000 || err_cnt !== 8'd1 || err !== 1'b0) begin
                failures++;
                $display("FAIL hold_%0d: locked=%b est=%b cnt=%0d err=%b, want 1 1000 1 0",
                         i, locked, state_est, err_cnt, err);
            end
        end
        // S15 emits 0x01 and always returns to S0.
        in_valid = 1'b1; cmd = 4'($urandom); obs = 8'h01;
        step();
        checks++;
        if (locked !== 1'b1 || state_est !== 4'b0000 || err !== 1'b0) begin
            failures++;
            $display("FAIL hold_resume: locked=%b est=%b err=%b, want 1 0000 0", locked, state_est, err);
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        in_valid = 1'b1; obs = 8'h03;
        for (int i = 0; i < 300; i++) begin
            cmd = 4'($urandom);
            step();
            if (i == 0 || i == 254 || i == 255) begin
                checks++;
                if (err_cnt !== ((i == 0) ? 8'd1 : 8'd255) || err !== 1'b1) begin
                    failures++;
                    $display("FAIL sat_at_%0d: cnt=%0d err=%b, want %0d 1",
                             i + 1, err_cnt, err, (i == 0) ? 1 : 255);
                end
            end
        end
        checks++;
        if (err_cnt !== 8'd255 || err !== 1'b1) begin
            failures++;
            $display("FAIL sat_300: cnt=%0d err=%b, want 255 1", err_cnt, err);
        end
    endtask

    task automatic test_lockstep();
        int src;
        apply_reset();
        src = 0;
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                in_valid = 1'b1; obs = 8'h03; cmd = 4'd0;
                step();
                checks++;
                if (err !== 1'b1 || err_cnt !== 8'd1) begin
                    failures++;
                    $display("FAIL lockstep_inject: err=%b cnt=%0d, want 1 1", err, err_cnt);
                end
                @(posedge clk);
                #3;
                rst_n = 1'b0;
                in_valid = 1'b0;
                #1;
                checks++;
                if (err_cnt !== 8'd0 || state_est !== 4'b0000 || locked !== 1'b1) begin
                    failures++;
                    $display("FAIL midrun_reset: cnt=%0d est=%b locked=%b, want 0 0000 1",
                             err_cnt, state_est, locked);
                end
                step();
                rst_n = 1'b1;
                src   = 0;
            end
            in_valid = ($urandom_range(0, 3) != 0);
            cmd      = 4'($urandom);
            obs      = in_valid ? out_tab[src] : 8'($urandom);
            step();
            if (in_valid)
                src = src_next(src, cmd);
            checks++;
            if (state_est !== code_tab[src] || locked !== 1'b1 || err !== 1'b0) begin
                failures++;
                $display("FAIL lockstep_%0d: est=%b locked=%b err=%b, want %b 1 0",
                         i, state_est, locked, err, code_tab[src]);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        cmd      = 4'd0;
        obs      = 8'h00;
        #12;
        rst_n = 1'b1;
        test_reset();
        test_first_lock();
        test_err_pulse();
        test_relock();
        test_hold();
        test_saturate();
        test_lockstep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_dsr_mon.md
GRAY_DSR_MON -- requirements
Module: gray_dsr_mon

Interface
REQ-001 SHALL have parameter ERR_W, default 8, meaning the width of the saturating error counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  source clock-enable; 1 = the source FSM advances this cycle and obs/cmd are meaningful.
REQ-005 SHALL have port cmd  input  4  the command presented to the source FSM in the same cycle.
REQ-006 SHALL have port obs  input  8  the source FSM's one-hot output in the same cycle.
REQ-007 SHALL have port locked  output  1  1 when exactly one source state is consistent with history.
REQ-008 SHALL have port state_est  output  4  Gray code of the source's current state when locked, else 4'b0000.
REQ-009 SHALL have port err  output  1  one-cycle pulse on an observation inconsistent with every candidate state.
REQ-010 SHALL have port err_cnt  output  ERR_W  saturating count of err pulses.

Function
REQ-011 SHALL hold a 16-bit candidate mask, where bit i set means the source may currently be in the state with Gray code i.
REQ-012 SHALL use the source state codes S0..S15 = 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000.
REQ-013 SHALL use the source output map: S0,S15->0x01; S1,S8->0x02; S2,S9->0x04; S3,S10->0x08; S4,S11->0x10; S5,S12->0x20; S6,S13->0x40; S7,S14->0x80.
REQ-014 SHALL define match(obs) as the two-state set for a legal one-hot obs, and the empty set for any obs not exactly one-hot (including 0x00).
REQ-015 SHALL compute filt = mask AND match(obs) each valid cycle.
REQ-016 SHALL use these source transitions for the successor set succ(set,cmd):
  - S0: cmd[0]?S1:S8
  - S1: cmd[1:0]==11?S2:S0
  - S2->S3
  - S3: cmd[2]?S4:S1
  - S4: cmd[3]?S5:S12
  - S5->S6
  - S6: cmd!=0?S7:S4
  - S7->S0
  - S8: cmd[3:2]==01?S9:S15
  - S9->S10
  - S10: cmd[1]?S11:S9
  - S11->S12
  - S12: cmd[0]^cmd[1]?S13:S14
  - S13->S0
  - S14->S15
  - S15->S0
REQ-017 SHALL, with in_valid=1 and filt nonzero, load mask <= succ(filt,cmd) and register err=0.
REQ-018 SHALL, with in_valid=1 and filt zero, load mask <= 16'hFFFF (unlocked), register err=1 for exactly one cycle and increment err_cnt.
REQ-019 SHALL, with in_valid=0, hold mask, register err=0 and perform no checking.
REQ-020 SHALL saturate err_cnt at all-ones, with no wrap.
REQ-021 SHALL derive locked combinationally from the mask register as popcount(mask)==1.
REQ-022 SHALL derive state_est combinationally as the index of the single set bit when locked, else 0.
REQ-023 SHALL have the mask register describe the source state in the cycle the mask is visible, giving zero latency relative to the source state register.

Reset
REQ-024 SHALL, on rst_n low, asynchronously set mask=16'h0001 (S0 only), err=0 and err_cnt=0, so locked=1 and state_est=0000 during reset.
REQ-025 SHALL, on reset mid-operation, discard all history and relock to S0, matching the source reset.

Structure
REQ-026 SHALL place state codes, the output map and the match function in shared package gray_dsr_pkg, for reuse by the source FSM and testbenches.
REQ-027 SHALL implement succ as combinational sub-module gray_dsr_succ (16-bit set in, cmd in, 16-bit set out), instantiated once.

Verification
REQ-028 SHALL verify: after reset, in_valid=1, cmd=0001, obs=0x01 -> next cycle locked=1, state_est=0001, err=0.
REQ-029 SHALL verify: from reset state, obs=0x04 -> next cycle err=1 for one cycle, err_cnt=1, locked=0, state_est=0000.
REQ-030 SHALL verify relock from unlocked:
  - obs=0x80 then obs=0x01 with cmd=0000 -> locked=0 (mask {S0,S8}).
  - then obs=0x02 with cmd=0000 -> locked=1, state_est=1000.
REQ-031 SHALL verify: obs=0x03 or 0x00 in any state -> err pulse; 300 consecutive bad observations -> err_cnt=255, with no wrap.
REQ-032 SHALL verify: in_valid=0 for 5 cycles with random obs/cmd -> mask, err_cnt and state_est unchanged.
REQ-033 SHALL verify: lockstep against the real source FSM with 10k random cmds -> err never asserts and state_est equals the source state every cycle; rst_n asserted mid-run -> err_cnt=0, state_est=0000.
